// File: rtl/gigex_device_model.sv
// Synthesizable stand-in for the GigExpedite byte interface on eth_clk: sinks FPGA Tx bytes
// into per-channel word FIFOs with nTF flow control, and sources host words as Rx bytes.
module gigex_device_model #(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned WORD_DEPTH = 4,
  parameter int unsigned TF_MARGIN  = 6,
  parameter int unsigned RX_CHAN    = 0,
  parameter int unsigned RX_GAP     = 2
) (
  input  logic        eth_clk,
  input  logic        rst_n,
  input  logic [7:0]  D,
  input  logic        nTx,
  input  logic [2:0]  TC,
  output logic [7:0]  nTF,
  output logic [7:0]  Q,
  output logic        nRx,
  output logic [2:0]  RC,
  input  logic [7:0]  nRF,
  output logic [31:0] rx_word,
  output logic [2:0]  rx_chan,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [31:0] host_tx_data,
  input  logic        host_tx_valid,
  output logic        host_tx_ready,
  output logic [7:0]  overflow,
  output logic        bad_chan
);

  localparam int unsigned PtrW     = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
  localparam int unsigned CntW     = $clog2(WORD_DEPTH + 1);
  localparam int unsigned TfThresh = 4 * WORD_DEPTH - TF_MARGIN;
  localparam int unsigned GapW     = (RX_GAP > 1) ? $clog2(RX_GAP) : 1;

  // ---------------------------------------------------------------------------------------------
  // Tx sink
  // ---------------------------------------------------------------------------------------------
  logic [23:0]     shift_q [CHANNELS];
  logic [1:0]      bcnt_q  [CHANNELS];
  logic [1:0]      bcnt_d  [CHANNELS];
  logic [31:0]     mem_q   [CHANNELS][WORD_DEPTH];
  logic [PtrW-1:0] wptr_q  [CHANNELS];
  logic [PtrW-1:0] rptr_q  [CHANNELS];
  logic [CntW-1:0] cnt_q   [CHANNELS];
  logic [CntW-1:0] cnt_d   [CHANNELS];
  logic [31:0]     occ_d   [CHANNELS];

  logic [CHANNELS-1:0] byte_hit, push, pop, drop, held, held_d, ntf_q, ntf_d, ovf_q;
  logic                bad_q, tc_ok;

  logic [31:0] out_word_q, sel_word;
  logic [2:0]  out_chan_q, out_chan_d, sel_chan;
  logic        out_valid_q, out_valid_d, sel_valid, load, accept, out_free;

  always_comb begin
    tc_ok     = 32'(TC) < CHANNELS;
    accept    = out_valid_q && rx_ready;
    out_free  = !out_valid_q || rx_ready;
    sel_valid = 1'b0;
    sel_chan  = '0;
    sel_word  = '0;
    // Later iterations override: the highest non-empty channel wins.
    for (int c = 0; c < CHANNELS; c++) begin
      if (cnt_q[c] != '0) begin
        sel_valid = 1'b1;
        sel_chan  = 3'(c);
        sel_word  = mem_q[c][rptr_q[c]];
      end
    end
    load        = out_free && sel_valid;
    out_valid_d = load || (out_valid_q && !accept);
    out_chan_d  = load ? sel_chan : out_chan_q;

    for (int c = 0; c < CHANNELS; c++) begin
      byte_hit[c] = !nTx && tc_ok && (32'(TC) == c);
      held[c]     = out_valid_q && (out_chan_q == 3'(c));
      held_d[c]   = out_valid_d && (out_chan_d == 3'(c));
      pop[c]      = load && (sel_chan == 3'(c));
      // The word parked in the output register still counts against its channel's depth.
      push[c]     = byte_hit[c] && (bcnt_q[c] == 2'd3) &&
                    ((32'(cnt_q[c]) + 32'(held[c])) < WORD_DEPTH);
      drop[c]     = byte_hit[c] && (bcnt_q[c] == 2'd3) && !push[c];
      cnt_d[c]    = cnt_q[c] + CntW'(push[c]) - CntW'(pop[c]);
      bcnt_d[c]   = byte_hit[c] ? bcnt_q[c] + 2'd1 : bcnt_q[c];
      occ_d[c]    = 4 * (32'(cnt_d[c]) + 32'(held_d[c])) + 32'(bcnt_d[c]);
      ntf_d[c]    = occ_d[c] < TfThresh;
    end
  end

  always_ff @(posedge eth_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        shift_q[c] <= '0;
        bcnt_q[c]  <= '0;
        cnt_q[c]   <= '0;
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
      end
      ntf_q       <= '1;
      ovf_q       <= '0;
      bad_q       <= 1'b0;
      out_word_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (byte_hit[c]) shift_q[c] <= {shift_q[c][15:0], D};
        bcnt_q[c] <= bcnt_d[c];
        cnt_q[c]  <= cnt_d[c];
        if (push[c]) begin
          wptr_q[c] <= (wptr_q[c] == PtrW'(WORD_DEPTH - 1)) ? '0 : wptr_q[c] + 1'b1;
        end
        if (pop[c]) begin
          rptr_q[c] <= (rptr_q[c] == PtrW'(WORD_DEPTH - 1)) ? '0 : rptr_q[c] + 1'b1;
        end
        if (drop[c]) ovf_q[c] <= 1'b1;
      end
      ntf_q <= ntf_d;
      if (!nTx && !tc_ok) bad_q <= 1'b1;
      if (load) out_word_q <= sel_word;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge eth_clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (push[c]) mem_q[c][wptr_q[c]] <= {shift_q[c], D};
    end
  end

  always_comb begin
    nTF      = '0;
    overflow = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      nTF[c]      = ntf_q[c];
      overflow[c] = ovf_q[c];
    end
  end

  assign rx_word  = out_word_q;
  assign rx_chan  = out_chan_q;
  assign rx_valid = out_valid_q;
  assign bad_chan = bad_q;

  // ---------------------------------------------------------------------------------------------
  // Rx source FSM
  // ---------------------------------------------------------------------------------------------
  typedef enum logic [1:0] {StIdle, StSend, StGap} rx_state_e;

  rx_state_e       rx_state_q, rx_state_d;
  logic [1:0]      k_q, k_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [31:0]     word_q, word_d;
  logic [7:0]      q_q, q_d;
  logic            nrx_q, nrx_d, ready_q, ready_d, nrf_q;
  logic            unused_nrf;

  assign unused_nrf = ^nRF;

  always_ff @(posedge eth_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= StIdle;
      k_q        <= '0;
      gap_q      <= '0;
      word_q     <= '0;
      q_q        <= '0;
      nrx_q      <= 1'b1;
      ready_q    <= 1'b0;
      nrf_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      k_q        <= k_d;
      gap_q      <= gap_d;
      word_q     <= word_d;
      q_q        <= q_d;
      nrx_q      <= nrx_d;
      ready_q    <= ready_d;
      nrf_q      <= nRF[RX_CHAN];
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    k_d        = k_q;
    gap_d      = gap_q;
    word_d     = word_q;
    unique case (rx_state_q)
      StIdle: begin
        if (host_tx_valid && ready_q) begin
          word_d     = host_tx_data;
          k_d        = '0;
          rx_state_d = StSend;
        end
      end
      StSend: begin
        if (nrf_q) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            gap_d      = '0;
            rx_state_d = (RX_GAP == 0) ? StIdle : StGap;
          end
        end
      end
      StGap: begin
        if (32'(gap_q) == RX_GAP - 1) rx_state_d = StIdle;
        else                          gap_d      = gap_q + 1'b1;
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_comb begin
    q_d     = q_q;
    nrx_d   = 1'b1;
    ready_d = (rx_state_d == StIdle);
    if (rx_state_q == StSend && nrf_q) begin
      nrx_d = 1'b0;
      unique case (k_q)
        2'd0:    q_d = word_q[31:24];
        2'd1:    q_d = word_q[23:16];
        2'd2:    q_d = word_q[15:8];
        default: q_d = word_q[7:0];
      endcase
    end
  end

  assign Q             = q_q;
  assign nRx           = nrx_q;
  assign RC            = 3'(RX_CHAN);
  assign host_tx_ready = ready_q;

endmodule

// File: tb/tb_gigex_device_model.sv
// Bench for gigex_device_model: directed scenarios plus randomized traffic scored against a
// queue-based model of channel buffers, flow-control occupancy and the Rx byte stream.
module tb_gigex_device_model;

  logic        eth_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [7:0]  D, nTF, Q, nRF, overflow;
  logic        nTx, nRx, rx_valid, rx_ready, host_tx_valid, host_tx_ready, bad_chan;
  logic [2:0]  TC, RC, rx_chan;
  logic [31:0] rx_word, host_tx_data;

  gigex_device_model dut (
    .eth_clk       (eth_clk),
    .rst_n         (rst_n),
    .D             (D),
    .nTx           (nTx),
    .TC            (TC),
    .nTF           (nTF),
    .Q             (Q),
    .nRx           (nRx),
    .RC            (RC),
    .nRF           (nRF),
    .rx_word       (rx_word),
    .rx_chan       (rx_chan),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .host_tx_data  (host_tx_data),
    .host_tx_valid (host_tx_valid),
    .host_tx_ready (host_tx_ready),
    .overflow      (overflow),
    .bad_chan      (bad_chan)
  );

  always #5 eth_clk = ~eth_clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: each channel is a queue of words not yet taken by the consumer.
  logic [31:0] mq [3][$];
  int          m_bcnt [3];
  logic [31:0] m_part [3];
  logic [7:0]  m_ovf;
  logic        m_bad;
  logic [7:0]  rxq [$];
  logic [2:0]  log_chan [$];
  logic [31:0] log_word [$];

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      mq[c].delete();
      m_bcnt[c] = 0;
      m_part[c] = '0;
    end
    m_ovf = '0;
    m_bad = 1'b0;
    rxq.delete();
  endtask

  function automatic logic [7:0] exp_ntf();
    logic [7:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) r[c] = (4 * mq[c].size() + m_bcnt[c]) < 10;
    return r;
  endfunction

  task automatic set_idle();
    nTx = 1'b1; TC = '0; D = '0; rx_ready = 1'b0; nRF = 8'hFF;
    host_tx_valid = 1'b0; host_tx_data = '0;
  endtask

  // One clock: score the handshake about to happen, advance the model, then check post-edge state.
  task automatic tick();
    logic       acc, legal;
    logic [2:0] ac;
    logic [7:0] eb;
    acc = rx_valid && rx_ready;
    ac  = rx_chan;
    if (acc) begin
      legal = (ac < 3) ? (mq[ac].size() != 0) : 1'b0;
      chk("rx_word_queued", 32'(legal), 1);
      if (legal) begin
        chk("rx_word", rx_word, mq[ac][0]);
        log_chan.push_back(ac);
        log_word.push_back(rx_word);
      end else begin
        acc = 1'b0;
      end
    end
    if (!nTx) begin
      if (TC > 2) m_bad = 1'b1;
      else begin
        m_part[TC] = {m_part[TC][23:0], D};
        m_bcnt[TC]++;
        if (m_bcnt[TC] == 4) begin
          m_bcnt[TC] = 0;
          if (mq[TC].size() >= 4) m_ovf[TC] = 1'b1;
          else                    mq[TC].push_back(m_part[TC]);
        end
      end
    end
    if (acc) void'(mq[ac].pop_front());
    if (host_tx_valid && host_tx_ready) begin
      for (int k = 3; k >= 0; k--) rxq.push_back(8'(host_tx_data >> (8 * k)));
    end
    @(posedge eth_clk);
    #1;
    chk("nTF", nTF, exp_ntf());
    chk("overflow", overflow, m_ovf);
    chk("bad_chan", bad_chan, m_bad);
    if (!nRx) begin
      chk("rx_byte_queued", 32'(rxq.size() != 0), 1);
      if (rxq.size() != 0) begin
        eb = rxq.pop_front();
        chk("Q", Q, eb);
      end
    end
  endtask

  task automatic send_byte(input logic [2:0] tc, input logic [7:0] d);
    nTx = 1'b0; TC = tc; D = d;
    tick();
    nTx = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge eth_clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!rx_valid && lat < 3) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         lat;
    logic [7:0] s4 [24];
    logic [2:0] seq_tc [10];
    logic [7:0] seq_d  [10];
    int         left;

    set_idle();
    model_reset();
    repeat (2) @(posedge eth_clk);
    #1;
    chk("rst_nTF", nTF, 8'h07);
    chk("rst_nRx", nRx, 1);
    chk("rst_Q", Q, 0);
    chk("rst_RC", RC, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_word", rx_word, 0);
    chk("rst_rx_chan", rx_chan, 0);
    chk("rst_ready", host_tx_ready, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_bad_chan", bad_chan, 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", host_tx_ready, 1);
    chk("valid_after_reset", rx_valid, 0);

    // Single word on the cmd channel.
    rx_ready = 1'b1;
    send_byte(3'd1, 8'hDE); send_byte(3'd1, 8'hAD);
    send_byte(3'd1, 8'hBE); send_byte(3'd1, 8'hEF);
    wait_valid(lat);
    chk("t2_latency", 32'(rx_valid && lat <= 2), 1);
    chk("t2_word", rx_word, 32'hDEADBEEF);
    chk("t2_chan", rx_chan, 1);
    tick();
    chk("t2_one_cycle", rx_valid, 0);

    // Interleaved channels reassemble independently.
    log_chan.delete(); log_word.delete();
    seq_tc = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
    seq_d  = '{8'h11, 8'h22, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h33, 8'h44, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) send_byte(seq_tc[i], seq_d[i]);
    repeat (4) tick();
    chk("t3_count", log_word.size(), 2);
    if (log_word.size() >= 2) begin
      chk("t3_first_chan", log_chan[0], 2);
      chk("t3_first_word", log_word[0], 32'hA1A2A3A4);
      chk("t3_second_chan", log_chan[1], 0);
      chk("t3_second_word", log_word[1], 32'h11223344);
    end

    // Back-pressure: flow control and overflow on channel 0.
    rx_ready = 1'b0;
    log_chan.delete(); log_word.delete();
    for (int i = 0; i < 24; i++) begin
      s4[i] = 8'($urandom);
      send_byte(3'd0, s4[i]);
      chk("t4_ntf0", nTF[0], 32'((i + 1) < 10));
    end
    chk("t4_overflow", overflow[0], 1);
    rx_ready = 1'b1;
    repeat (8) tick();
    chk("t4_words", log_word.size(), 4);
    for (int k = 0; k < 4 && k < log_word.size(); k++) begin
      chk("t4_word", log_word[k], {s4[4*k], s4[4*k+1], s4[4*k+2], s4[4*k+3]});
    end

    // Rx word with no back-pressure.
    host_tx_data = 32'h12345678; host_tx_valid = 1'b1;
    chk("t5_ready", host_tx_ready, 1);
    tick();
    host_tx_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_nRx", nRx, 0);
      chk("t5_Q", Q, 32'((32'h12345678 >> (24 - 8 * k)) & 32'hFF));
    end
    tick();
    chk("t5_gap1_nRx", nRx, 1);
    chk("t5_gap1_ready", host_tx_ready, 0);
    tick();
    chk("t5_gap2_nRx", nRx, 1);
    chk("t5_gap_end_ready", host_tx_ready, 1);

    // Rx word paused by nRF[0].
    host_tx_valid = 1'b1;
    tick();
    host_tx_valid = 1'b0;
    tick();
    chk("t6_b0", Q, 8'h12);
    nRF = 8'hFE;
    tick();
    chk("t6_b1", Q, 8'h34);
    chk("t6_b1_nRx", nRx, 0);
    tick();
    chk("t6_pause1", nRx, 1);
    tick();
    chk("t6_pause2", nRx, 1);
    nRF = 8'hFF;
    tick();
    chk("t6_pause3", nRx, 1);
    tick();
    chk("t6_b2", Q, 8'h56);
    chk("t6_b2_nRx", nRx, 0);
    tick();
    chk("t6_b3", Q, 8'h78);
    repeat (2) tick();
    chk("t6_ready", host_tx_ready, 1);

    // Reset in the middle of both directions.
    host_tx_data = 32'hAABBCCDD; host_tx_valid = 1'b1;
    nTx = 1'b0; TC = 3'd0; D = 8'h01;
    tick();
    host_tx_valid = 1'b0; D = 8'h02;
    tick();
    nTx = 1'b1;
    tick();
    chk("t7_b1_nRx", nRx, 0);
    chk("t7_b1_Q", Q, 8'hBB);
    rst_n = 1'b0;
    #1;
    chk("t7_async_nRx", nRx, 1);
    chk("t7_async_nTF", nTF, 8'h07);
    model_reset();
    repeat (2) @(posedge eth_clk);
    #1;
    rst_n = 1'b1;
    tick();
    rx_ready = 1'b1;
    send_byte(3'd0, 8'hDE); send_byte(3'd0, 8'hAD);
    send_byte(3'd0, 8'hBE); send_byte(3'd0, 8'hEF);
    wait_valid(lat);
    chk("t7_latency", 32'(rx_valid && lat <= 2), 1);
    chk("t7_word", rx_word, 32'hDEADBEEF);
    chk("t7_chan", rx_chan, 0);
    tick();

    // Randomized traffic on both directions.
    set_idle();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      nTx           = 1'($urandom_range(0, 1));
      TC            = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      D             = 8'($urandom);
      rx_ready      = ($urandom_range(0, 3) != 0);
      nRF           = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'hFF;
      host_tx_valid = 1'($urandom_range(0, 1));
      host_tx_data  = $urandom;
      tick();
    end
    set_idle();
    rx_ready = 1'b1;
    repeat (40) tick();
    left = mq[0].size() + mq[1].size() + mq[2].size();
    chk("drain_tx_words", left, 0);
    chk("drain_rx_bytes", rxq.size(), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
